// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side and shared-port signals of the 4:1 round-robin arbiter.
// The master modport is the arbiter; slave is whatever drives and observes it.
interface mux4_rr_arbiter_if #(
  parameter int unsigned AW = 32
);
   logic [3:0]      req;
   logic [4*AW-1:0] req_addr;
   logic            m_valid;
   logic            m_ready;
   logic [AW-1:0]   m_addr;
   logic            m_done;
   logic [1:0]      sel;
   logic [3:0]      gnt;
   logic [3:0]      done;
   logic            busy;

   modport master (
      input  req, req_addr, m_ready, m_done,
      output m_valid, m_addr, sel, gnt, done, busy
   );

   modport slave (
      output req, req_addr, m_ready, m_done,
      input  m_valid, m_addr, sel, gnt, done, busy
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer: grants one of four requesters, issues its address on the
// shared port with valid/ready, waits for completion and pulses done back to the winner.
module mux4_rr_arbiter #(
  parameter int unsigned AW = 32
) (
   input logic               clk,
   input logic               resetn,
   mux4_rr_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e        state_q;
   logic [1:0]    ptr_q;
   logic [1:0]    sel_q;
   logic [3:0]    gnt_q;
   logic [3:0]    done_q;
   logic          m_valid_q;
   logic [AW-1:0] m_addr_q;
   logic          busy_q;

   logic [1:0]    win;
   logic [1:0]    cand;
   logic          win_vld;
   logic [AW-1:0] win_addr;

   // Scan from the highest offset down so the lowest offset from ptr is assigned last.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr_q + 2'(i);
         if (bus.req[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      win_addr = '0;
      case (win)
         2'd0:    win_addr = bus.req_addr[0*AW +: AW];
         2'd1:    win_addr = bus.req_addr[1*AW +: AW];
         2'd2:    win_addr = bus.req_addr[2*AW +: AW];
         default: win_addr = bus.req_addr[3*AW +: AW];
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         sel_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         m_valid_q <= 1'b0;
         m_addr_q  <= '0;
         busy_q    <= 1'b0;
      end else begin
         done_q <= '0;
         case (state_q)
            StIdle: begin
               if (win_vld) begin
                  sel_q     <= win;
                  gnt_q     <= 4'b0001 << win;
                  m_addr_q  <= win_addr;
                  m_valid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               // Completion is only meaningful once the request has been accepted.
               if (bus.m_ready) begin
                  m_valid_q <= 1'b0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               if (bus.m_done) begin
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  ptr_q   <= sel_q + 2'd1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.sel     = sel_q;
   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed and randomized transactions checked
// against a transaction-level round-robin model.
module tb_mux4_rr_arbiter;
   localparam int unsigned AW = 32;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mux4_rr_arbiter_if #(.AW(AW)) bus ();

   mux4_rr_arbiter #(.AW(AW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_grant = 0;
   int m_ptr    = 0;
   logic [AW-1:0] addr [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_addr();
      for (int i = 0; i < 4; i++) bus.req_addr[i*AW +: AW] = addr[i];
   endtask

   // First pending requester at or after the pointer, wrapping modulo 4.
   function automatic int model_winner(input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return 0;
   endfunction

   task automatic idle_chk();
      bus.req = 4'b0;
      tick();
      chk("idle_gnt", bus.gnt, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_valid", bus.m_valid, 0);
   endtask

   task automatic run_txn(input logic [3:0] r, input int rdly, input int ddly, input bit keep,
                          input bit early_done, input bit chk_spacing);
      int w;
      logic [AW-1:0] ea;
      logic [3:0] eg;
      bus.req = r;
      w  = model_winner(r);
      ea = addr[w];
      eg = 4'b0001 << w;
      tick();
      if (chk_spacing) chk("spacing", AW'(cyc - last_grant), 3);
      last_grant = cyc;
      chk("grant_sel", bus.sel, AW'(w));
      chk("grant_gnt", bus.gnt, eg);
      chk("grant_valid", bus.m_valid, 1);
      chk("grant_busy", bus.busy, 1);
      chk("grant_addr", bus.m_addr, ea);
      chk("grant_done", bus.done, 0);
      bus.req = keep ? r : 4'b0;
      for (int s = 0; s < rdly; s++) begin
         addr[w] = $urandom;
         drive_addr();
         if (!keep) bus.req = 4'($urandom);
         bus.m_done = early_done && (s == 0);
         tick();
         bus.m_done = 1'b0;
         chk("stall_valid", bus.m_valid, 1);
         chk("stall_addr", bus.m_addr, ea);
         chk("stall_sel", bus.sel, AW'(w));
         chk("stall_gnt", bus.gnt, eg);
         chk("stall_done", bus.done, 0);
      end
      bus.req = keep ? r : 4'b0;
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      chk("accept_valid", bus.m_valid, 0);
      chk("accept_busy", bus.busy, 1);
      chk("accept_gnt", bus.gnt, eg);
      for (int s = 0; s < ddly; s++) begin
         tick();
         chk("wait_done", bus.done, 0);
         chk("wait_gnt", bus.gnt, eg);
         chk("wait_busy", bus.busy, 1);
      end
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      chk("done_pulse", bus.done, eg);
      chk("done_gnt", bus.gnt, 0);
      chk("done_busy", bus.busy, 0);
      chk("done_valid", bus.m_valid, 0);
      chk("done_sel", bus.sel, AW'(w));
      m_ptr = (w + 1) % 4;
   endtask

   initial begin
      logic [3:0] r;
      int rd;
      bus.req     = 4'b0;
      bus.m_ready = 1'b0;
      bus.m_done  = 1'b0;
      for (int i = 0; i < 4; i++) addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      drive_addr();

      #12;
      chk("rst_sel", bus.sel, 0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_addr", bus.m_addr, 0);
      chk("rst_busy", bus.busy, 0);
      resetn = 1'b1;
      m_ptr  = 0;
      tick();
      idle_chk();

      // All four requesting: expect 0,1,2,3,0,1 at 3-cycle spacing.
      for (int i = 0; i < 6; i++) run_txn(4'b1111, 0, 0, 1'b1, 1'b0, i > 0);
      idle_chk();

      // Pointer wrap: grant 3, then 1001 picks 0, then 3.
      run_txn(4'b1000, 0, 0, 1'b0, 1'b0, 1'b0);
      run_txn(4'b1001, 0, 0, 1'b0, 1'b0, 1'b0);
      run_txn(4'b1001, 0, 0, 1'b0, 1'b0, 1'b0);
      idle_chk();

      // Single request to requester 2; pointer should move to 3.
      addr[2] = 32'h1FC0_0010;
      drive_addr();
      run_txn(4'b0100, 0, 0, 1'b0, 1'b0, 1'b0);
      run_txn(4'b1011, 0, 0, 1'b0, 1'b0, 1'b0);
      idle_chk();

      // Ready stall with owner req/address changing, plus an ignored early done.
      run_txn(4'b1111, 5, 2, 1'b0, 1'b1, 1'b0);
      idle_chk();

      for (int n = 0; n < 40; n++) begin
         r = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) addr[i] = $urandom;
         drive_addr();
         rd = $urandom_range(0, 3);
         run_txn(r, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 (rd > 0) && ($urandom_range(0, 1) == 1), 1'b0);
         if ($urandom_range(0, 2) == 0) idle_chk();
      end
      idle_chk();

      // Reset in WAIT with a nonzero pointer: everything clears at once, no done.
      run_txn(4'b0001, 0, 0, 1'b0, 1'b0, 1'b0);
      bus.req = 4'b0010;
      tick();
      chk("pre_rst_gnt", bus.gnt, 4'b0010);
      bus.req = 4'b0;
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      tick();
      resetn = 1'b0;
      #1;
      chk("async_gnt", bus.gnt, 0);
      chk("async_sel", bus.sel, 0);
      chk("async_busy", bus.busy, 0);
      chk("async_valid", bus.m_valid, 0);
      chk("async_done", bus.done, 0);
      m_ptr = 0;
      #3;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_done", bus.done, 0);
         chk("post_rst_busy", bus.busy, 0);
      end
      run_txn(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);
      idle_chk();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
